// File: rtl/ew_fifo_pack.sv
// Packs the 32-bit event-window word stream into 64-bit beats for the ping-pong EW_FIFOs.
// Emits one descriptor per window to the DDR/AXI writer over valid/ready.
module ew_fifo_pack #(
  parameter int          EVENT_SIZE_BITS = 16,
  parameter int          BEAT_BITS       = EVENT_SIZE_BITS + 1,
  parameter logic [31:0] PAD_WORD        = 32'h0000_0000
) (
  input  logic                       serdesclk,
  input  logic                       resetn_serdesclk,
  input  logic                       ew_fifo_we,
  input  logic [31:0]                ew_data,
  input  logic                       curr_ewfifo_wr,
  input  logic                       ew_done,
  input  logic [EVENT_SIZE_BITS-1:0] ew_size,
  input  logic [19:0]                ew_tag,
  input  logic                       ew_ovfl,
  input  logic                       ewfifo0_full,
  input  logic                       ewfifo1_full,
  output logic                       ewfifo0_we,
  output logic                       ewfifo1_we,
  output logic [63:0]                ewfifo_wdata,
  output logic                       desc_valid,
  input  logic                       desc_ready,
  output logic [EVENT_SIZE_BITS-1:0] desc_size,
  output logic [19:0]                desc_tag,
  output logic                       desc_ovfl,
  output logic                       desc_buf,
  output logic [BEAT_BITS-1:0]       desc_beats,
  output logic                       size_err,
  output logic                       drop_err
);

  typedef enum logic [1:0] {FILL, FLUSH, DESC} state_t;

  state_t                     state_q, state_d;
  logic                       half_valid_q, half_valid_d;
  logic [31:0]                lo_q, lo_d;
  logic                       win_active_q, win_active_d;
  logic                       buf_q, buf_d;
  logic [BEAT_BITS-1:0]       beat_cnt_q, beat_cnt_d;
  logic                       ewfifo0_we_q, ewfifo0_we_d;
  logic                       ewfifo1_we_q, ewfifo1_we_d;
  logic [63:0]                wdata_q, wdata_d;
  logic                       desc_valid_q, desc_valid_d;
  logic [EVENT_SIZE_BITS-1:0] desc_size_q, desc_size_d;
  logic [19:0]                desc_tag_q, desc_tag_d;
  logic                       desc_ovfl_q, desc_ovfl_d;
  logic                       desc_buf_q, desc_buf_d;
  logic [BEAT_BITS-1:0]       desc_beats_q, desc_beats_d;
  logic                       size_err_q, size_err_d;
  logic                       drop_err_q, drop_err_d;

  logic                       issue;
  logic [63:0]                beat;
  logic                       pad_flush;
  logic                       target_full;
  logic [BEAT_BITS-1:0]       size_ext;

  always_comb begin
    state_d      = state_q;
    half_valid_d = half_valid_q;
    lo_d         = lo_q;
    win_active_d = win_active_q;
    buf_d        = buf_q;
    beat_cnt_d   = beat_cnt_q;
    ewfifo0_we_d = 1'b0;
    ewfifo1_we_d = 1'b0;
    wdata_d      = wdata_q;
    desc_valid_d = desc_valid_q;
    desc_size_d  = desc_size_q;
    desc_tag_d   = desc_tag_q;
    desc_ovfl_d  = desc_ovfl_q;
    desc_buf_d   = desc_buf_q;
    desc_beats_d = desc_beats_q;
    size_err_d   = size_err_q;
    drop_err_d   = drop_err_q;
    issue        = 1'b0;
    beat         = wdata_q;
    pad_flush    = 1'b0;
    target_full  = 1'b0;
    size_ext     = BEAT_BITS'(ew_size);

    // Incoming word is always packed first, whatever the descriptor state.
    if (ew_fifo_we) begin
      if (!win_active_q) begin
        win_active_d = 1'b1;
        buf_d        = curr_ewfifo_wr;
      end
      if (!half_valid_q) begin
        lo_d         = ew_data;
        half_valid_d = 1'b1;
      end else begin
        issue        = 1'b1;
        beat         = {ew_data, lo_q};
        half_valid_d = 1'b0;
      end
    end

    if (ew_done && state_q == FILL && half_valid_d) begin
      pad_flush    = 1'b1;
      issue        = 1'b1;
      beat         = {PAD_WORD, lo_d};
      half_valid_d = 1'b0;
    end

    if (issue) begin
      target_full = buf_d ? ewfifo1_full : ewfifo0_full;
      if (target_full) begin
        drop_err_d = 1'b1;
      end else begin
        wdata_d      = beat;
        ewfifo0_we_d = !buf_d;
        ewfifo1_we_d = buf_d;
        if (!(&beat_cnt_d)) beat_cnt_d = beat_cnt_d + {{(BEAT_BITS-1){1'b0}}, 1'b1};
      end
    end

    case (state_q)
      FILL: begin
        if (ew_done) begin
          desc_size_d  = ew_size;
          desc_tag_d   = ew_tag;
          desc_ovfl_d  = ew_ovfl;
          desc_buf_d   = win_active_d ? buf_d : curr_ewfifo_wr;
          desc_beats_d = beat_cnt_d;
          size_err_d   = size_err_q | (beat_cnt_d != size_ext);
          state_d      = pad_flush ? FLUSH : DESC;
          desc_valid_d = !pad_flush;
        end
      end
      FLUSH: begin
        state_d      = DESC;
        desc_valid_d = 1'b1;
      end
      DESC: begin
        if (desc_ready) begin
          desc_valid_d = 1'b0;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // Window closes on every done; an overrun discards its descriptor.
    if (ew_done) begin
      if (state_q != FILL) drop_err_d = 1'b1;
      half_valid_d = 1'b0;
      win_active_d = 1'b0;
      beat_cnt_d   = '0;
    end
  end

  always_ff @(posedge serdesclk or negedge resetn_serdesclk) begin
    if (!resetn_serdesclk) begin
      state_q      <= FILL;
      half_valid_q <= 1'b0;
      lo_q         <= '0;
      win_active_q <= 1'b0;
      buf_q        <= 1'b0;
      beat_cnt_q   <= '0;
      ewfifo0_we_q <= 1'b0;
      ewfifo1_we_q <= 1'b0;
      wdata_q      <= '0;
      desc_valid_q <= 1'b0;
      desc_size_q  <= '0;
      desc_tag_q   <= '0;
      desc_ovfl_q  <= 1'b0;
      desc_buf_q   <= 1'b0;
      desc_beats_q <= '0;
      size_err_q   <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_valid_q <= half_valid_d;
      lo_q         <= lo_d;
      win_active_q <= win_active_d;
      buf_q        <= buf_d;
      beat_cnt_q   <= beat_cnt_d;
      ewfifo0_we_q <= ewfifo0_we_d;
      ewfifo1_we_q <= ewfifo1_we_d;
      wdata_q      <= wdata_d;
      desc_valid_q <= desc_valid_d;
      desc_size_q  <= desc_size_d;
      desc_tag_q   <= desc_tag_d;
      desc_ovfl_q  <= desc_ovfl_d;
      desc_buf_q   <= desc_buf_d;
      desc_beats_q <= desc_beats_d;
      size_err_q   <= size_err_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign ewfifo0_we   = ewfifo0_we_q;
  assign ewfifo1_we   = ewfifo1_we_q;
  assign ewfifo_wdata = wdata_q;
  assign desc_valid   = desc_valid_q;
  assign desc_size    = desc_size_q;
  assign desc_tag     = desc_tag_q;
  assign desc_ovfl    = desc_ovfl_q;
  assign desc_buf     = desc_buf_q;
  assign desc_beats   = desc_beats_q;
  assign size_err     = size_err_q;
  assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_ew_fifo_pack.sv
// Scoreboard bench for ew_fifo_pack: stimulus pushes expected beats/descriptors,
// a negedge monitor pops and compares whenever a FIFO write or descriptor handshake appears.
module tb_ew_fifo_pack;

  localparam logic [31:0] PAD = 32'h0000_0000;

  logic        serdesclk;
  logic        resetn_serdesclk;
  logic        ew_fifo_we;
  logic [31:0] ew_data;
  logic        curr_ewfifo_wr;
  logic        ew_done;
  logic [15:0] ew_size;
  logic [19:0] ew_tag;
  logic        ew_ovfl;
  logic        ewfifo0_full;
  logic        ewfifo1_full;
  logic        ewfifo0_we;
  logic        ewfifo1_we;
  logic [63:0] ewfifo_wdata;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_size;
  logic [19:0] desc_tag;
  logic        desc_ovfl;
  logic        desc_buf;
  logic [16:0] desc_beats;
  logic        size_err;
  logic        drop_err;

  int checks = 0;
  int errors = 0;

  // Expected beat = {buffer, data}; expected descriptor = {size, tag, ovfl, buf, beats}.
  logic [64:0] beatQ[$];
  logic [54:0] descQ[$];

  ew_fifo_pack dut (
    .serdesclk        (serdesclk),
    .resetn_serdesclk (resetn_serdesclk),
    .ew_fifo_we       (ew_fifo_we),
    .ew_data          (ew_data),
    .curr_ewfifo_wr   (curr_ewfifo_wr),
    .ew_done          (ew_done),
    .ew_size          (ew_size),
    .ew_tag           (ew_tag),
    .ew_ovfl          (ew_ovfl),
    .ewfifo0_full     (ewfifo0_full),
    .ewfifo1_full     (ewfifo1_full),
    .ewfifo0_we       (ewfifo0_we),
    .ewfifo1_we       (ewfifo1_we),
    .ewfifo_wdata     (ewfifo_wdata),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .desc_size        (desc_size),
    .desc_tag         (desc_tag),
    .desc_ovfl        (desc_ovfl),
    .desc_buf         (desc_buf),
    .desc_beats       (desc_beats),
    .size_err         (size_err),
    .drop_err         (drop_err)
  );

  initial serdesclk = 1'b0;
  always #5 serdesclk = ~serdesclk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every FIFO write and every accepted descriptor against the queues.
  always @(negedge serdesclk) begin
    if (resetn_serdesclk) begin
      if (ewfifo0_we || ewfifo1_we) begin
        if (ewfifo0_we && ewfifo1_we) checkOutput("both_we", 2'b11, 2'b01);
        if (beatQ.size() == 0) checkOutput("beat_unexpected", {ewfifo1_we, ewfifo_wdata}, 65'h0);
        else checkOutput("beat", {ewfifo1_we, ewfifo_wdata}, beatQ.pop_front());
      end
      if (desc_valid && desc_ready) begin
        if (descQ.size() == 0)
          checkOutput("desc_unexpected", {desc_size, desc_tag, desc_ovfl, desc_buf, desc_beats}, 55'h0);
        else
          checkOutput("desc", {desc_size, desc_tag, desc_ovfl, desc_buf, desc_beats}, descQ.pop_front());
      end
    end
  end

  // One window: n words from base, optional ew_done on the last word, optional beat hit by full.
  task automatic applyStimulus(input int n, input logic [31:0] base, input logic bsel,
                               input logic [15:0] size, input logic [19:0] tag, input logic ovfl,
                               input bit doneWithLast, input int fullBeat,
                               input logic [16:0] expBeats, input bit expDesc);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d              = base + i;
      curr_ewfifo_wr = (i == 0) ? bsel : ~bsel;
      ew_fifo_we     = 1'b1;
      ew_data        = d;
      ew_done        = doneWithLast && (i == n - 1);
      ew_size        = size;
      ew_tag         = tag;
      ew_ovfl        = ovfl;
      if (i % 2 == 1) begin
        if (i / 2 == fullBeat) begin
          if (bsel) ewfifo1_full = 1'b1;
          else ewfifo0_full = 1'b1;
        end else begin
          beatQ.push_back({bsel, d, d - 32'd1});
        end
      end
      if (ew_done && (n % 2 == 1)) beatQ.push_back({bsel, PAD, d});
      @(posedge serdesclk); #1;
      ew_fifo_we   = 1'b0;
      ew_done      = 1'b0;
      ewfifo0_full = 1'b0;
      ewfifo1_full = 1'b0;
    end
    if (!doneWithLast) begin
      curr_ewfifo_wr = (n == 0) ? bsel : ~bsel;
      ew_done        = 1'b1;
      ew_size        = size;
      ew_tag         = tag;
      ew_ovfl        = ovfl;
      if (n % 2 == 1) beatQ.push_back({bsel, PAD, base + n - 1});
      @(posedge serdesclk); #1;
      ew_done = 1'b0;
    end
    if (expDesc) descQ.push_back({size, tag, ovfl, bsel, expBeats});
  endtask

  // Waits for all expected traffic to appear, with a bounded cycle budget.
  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((beatQ.size() != 0 || descQ.size() != 0 || desc_valid) && cyc < 100) begin
      @(posedge serdesclk); #1;
      cyc++;
    end
    checkOutput({name, "_drain_timeout"}, (cyc >= 100), 1'b0);
    repeat (2) @(posedge serdesclk);
    #1;
  endtask

  task automatic resetDut(input string name);
    resetn_serdesclk = 1'b0;
    #2;
    checkOutput({name, "_rst_we"}, {ewfifo0_we, ewfifo1_we}, 2'b00);
    checkOutput({name, "_rst_wdata"}, ewfifo_wdata, 64'h0);
    checkOutput({name, "_rst_desc"}, {desc_valid, desc_size, desc_tag, desc_ovfl, desc_buf, desc_beats}, 56'h0);
    checkOutput({name, "_rst_errs"}, {size_err, drop_err}, 2'b00);
    beatQ.delete();
    descQ.delete();
    @(posedge serdesclk);
    @(negedge serdesclk);
    resetn_serdesclk = 1'b1;
    @(posedge serdesclk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    resetn_serdesclk = 1'b0;
    ew_fifo_we       = 1'b0;
    ew_data          = '0;
    curr_ewfifo_wr   = 1'b0;
    ew_done          = 1'b0;
    ew_size          = '0;
    ew_tag           = '0;
    ew_ovfl          = 1'b0;
    ewfifo0_full     = 1'b0;
    ewfifo1_full     = 1'b0;
    desc_ready       = 1'b1;
    #12;
    resetDut("init");

    // Eight words to buffer 0, buffer select flips after the first word and must be ignored.
    applyStimulus(8, 32'hA000_0000, 1'b0, 16'd4, 20'h11111, 1'b0, 1'b0, -1, 17'd4, 1'b1);
    drain("t1");
    checkOutput("t1_errs", {size_err, drop_err}, 2'b00);

    // Odd word count: trailing word padded on flush.
    applyStimulus(5, 32'hB000_0000, 1'b1, 16'd3, 20'h22222, 1'b1, 1'b0, -1, 17'd3, 1'b1);
    drain("t2");
    checkOutput("t2_errs", {size_err, drop_err}, 2'b00);

    // ew_done coincides with the last (odd) word: word stored, then padded.
    applyStimulus(3, 32'hC000_0000, 1'b0, 16'd2, 20'h33333, 1'b0, 1'b1, -1, 17'd2, 1'b1);
    drain("t7");
    checkOutput("t7_errs", {size_err, drop_err}, 2'b00);

    // Empty window: descriptor only, buffer taken from curr_ewfifo_wr.
    applyStimulus(0, 32'h0, 1'b1, 16'd0, 20'h44444, 1'b0, 1'b0, -1, 17'd0, 1'b1);
    drain("t5");
    checkOutput("t5_errs", {size_err, drop_err}, 2'b00);

    // Descriptor back-pressure and overrun by a second window.
    desc_ready = 1'b0;
    applyStimulus(4, 32'hD000_0000, 1'b0, 16'd2, 20'h55555, 1'b0, 1'b0, -1, 17'd2, 1'b1);
    repeat (10) @(posedge serdesclk);
    #1;
    checkOutput("t4_held_valid", desc_valid, 1'b1);
    checkOutput("t4_held_fields", {desc_size, desc_tag, desc_buf, desc_beats}, {16'd2, 20'h55555, 1'b0, 17'd2});
    applyStimulus(2, 32'hE000_0000, 1'b1, 16'd1, 20'h66666, 1'b1, 1'b0, -1, 17'd1, 1'b0);
    @(posedge serdesclk); #1;
    checkOutput("t4_overrun_fields", {desc_size, desc_tag, desc_ovfl, desc_buf, desc_beats},
                {16'd2, 20'h55555, 1'b0, 1'b0, 17'd2});
    checkOutput("t4_errs", {size_err, drop_err}, 2'b01);
    desc_ready = 1'b1;
    drain("t4");

    resetDut("mid");

    // Beat 1 of 4 to a full buffer 1 is discarded.
    applyStimulus(8, 32'hF000_0000, 1'b1, 16'd4, 20'h77777, 1'b0, 1'b0, 1, 17'd3, 1'b1);
    drain("t3");
    checkOutput("t3_errs", {size_err, drop_err}, 2'b11);

    // Reset after three words: first beat written, partial beat lost, errors cleared.
    for (int i = 0; i < 3; i++) begin
      curr_ewfifo_wr = 1'b0;
      ew_fifo_we     = 1'b1;
      ew_data        = 32'h7000_0000 + i;
      if (i == 1) beatQ.push_back({1'b0, 32'h7000_0001, 32'h7000_0000});
      @(posedge serdesclk); #1;
      ew_fifo_we = 1'b0;
    end
    @(negedge serdesclk); #1;
    checkOutput("t6_pre_beats_left", beatQ.size(), 0);
    resetDut("t6");
    applyStimulus(8, 32'h9000_0000, 1'b0, 16'd4, 20'h88888, 1'b0, 1'b0, -1, 17'd4, 1'b1);
    drain("t6b");
    checkOutput("t6_errs", {size_err, drop_err}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
